tmr_fault_monitor: RTL and testbench



---
 rtl/tmr_fault_monitor.sv | 168 ++++++++++++++++
 tb/tb_tmr_fault_monitor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tmr_fault_monitor.sv
// Fault monitor behind the 2-of-3 voter: registers the majority, tracks which replica
// disagrees, declares persistent offenders faulted and raises a sticky double-fault alarm.
module tmr_fault_monitor #(
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             c_in,
  input  logic             clear,
  output logic             voted,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       fault_id,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam int RUN_W = $clog2(PERSIST + 1);

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2,
    DOUBLE  = 2'd3
  } state_t;

  state_t           r_state, r_state_nx;
  logic [RUN_W-1:0] r_run, r_run_nx;
  logic [1:0]       r_suspect, r_suspect_nx;
  logic [1:0]       r_fault_id, r_fault_id_nx;
  logic             r_alarm, r_alarm_nx;
  logic             r_voted;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_count;

  logic           w_maj;
  logic           w_mis_a, w_mis_b, w_mis_c, w_mis_any;
  logic [1:0]     w_mis_ch;
  logic [RUN_W:0] w_run_inc;
  logic [RUN_W:0] w_cand;
  logic [RUN_W:0] w_persist;

  assign w_maj     = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);
  assign w_mis_a   = a_in ^ w_maj;
  assign w_mis_b   = b_in ^ w_maj;
  assign w_mis_c   = c_in ^ w_maj;
  assign w_mis_any = w_mis_a | w_mis_b | w_mis_c;
  assign w_mis_ch  = w_mis_a ? 2'd1 : (w_mis_b ? 2'd2 : (w_mis_c ? 2'd3 : 2'd0));

  assign w_run_inc = {1'b0, r_run} + (RUN_W+1)'(1);
  assign w_persist = (RUN_W+1)'(PERSIST);
  // In FAULT the run restarts at 1 whenever the second offender changes identity.
  assign w_cand    = (w_mis_ch != r_suspect) ? (RUN_W+1)'(1) : w_run_inc;

  always_comb begin
    r_state_nx    = r_state;
    r_run_nx      = r_run;
    r_suspect_nx  = r_suspect;
    r_fault_id_nx = r_fault_id;
    r_alarm_nx    = r_alarm;
    if (clear) begin
      r_state_nx    = HEALTHY;
      r_run_nx      = '0;
      r_suspect_nx  = '0;
      r_fault_id_nx = '0;
      r_alarm_nx    = 1'b0;
    end else begin
      case (r_state)
        HEALTHY: begin
          if (w_mis_any) begin
            r_suspect_nx = w_mis_ch;
            if (PERSIST == 1) begin
              r_state_nx    = FAULT;
              r_fault_id_nx = w_mis_ch;
              r_run_nx      = '0;
            end else begin
              r_state_nx = SUSPECT;
              r_run_nx   = RUN_W'(1);
            end
          end
        end
        SUSPECT: begin
          if (!w_mis_any) begin
            r_state_nx = HEALTHY;
            r_run_nx   = '0;
          end else if (w_mis_ch == r_suspect) begin
            if (w_run_inc == w_persist) begin
              r_state_nx    = FAULT;
              r_fault_id_nx = r_suspect;
              r_run_nx      = '0;
            end else begin
              r_run_nx = w_run_inc[RUN_W-1:0];
            end
          end else begin
            r_suspect_nx = w_mis_ch;
            r_run_nx     = RUN_W'(1);
          end
        end
        FAULT: begin
          if (!w_mis_any || (w_mis_ch == r_fault_id)) begin
            r_run_nx = '0;
          end else begin
            r_suspect_nx = w_mis_ch;
            if (w_cand == w_persist) begin
              r_state_nx = DOUBLE;
              r_alarm_nx = 1'b1;
              r_run_nx   = '0;
            end else begin
              r_run_nx = w_cand[RUN_W-1:0];
            end
          end
        end
        DOUBLE: begin
          r_alarm_nx = 1'b1;
        end
        default: begin
          r_state_nx = HEALTHY;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= HEALTHY;
      r_run      <= '0;
      r_suspect  <= '0;
      r_fault_id <= '0;
      r_alarm    <= 1'b0;
    end else begin
      r_state    <= r_state_nx;
      r_run      <= r_run_nx;
      r_suspect  <= r_suspect_nx;
      r_fault_id <= r_fault_id_nx;
      r_alarm    <= r_alarm_nx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_voted     <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_voted <= w_maj;
      if (clear) begin
        r_err_pulse <= 1'b0;
        r_err_count <= '0;
      end else begin
        r_err_pulse <= w_mis_any;
        if (w_mis_any && (r_err_count != '1)) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
      end
    end
  end

  assign voted     = r_voted;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign fault_id  = r_fault_id;
  assign alarm     = r_alarm;
  assign state     = r_state;

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed bench for tmr_fault_monitor: four instances with different CNT_W/PERSIST
// share one stimulus stream; each check targets the instance its scenario needs.
module tb_tmr_fault_monitor;

  logic clk;
  logic rst;
  logic ta, tb, tc, tclr;

  logic       p3_voted, p3_pulse, p3_alarm;
  logic [7:0] p3_cnt;
  logic [1:0] p3_fid, p3_state;
  logic       p2_voted, p2_pulse, p2_alarm;
  logic [7:0] p2_cnt;
  logic [1:0] p2_fid, p2_state;
  logic       c4_voted, c4_pulse, c4_alarm;
  logic [3:0] c4_cnt;
  logic [1:0] c4_fid, c4_state;
  logic       p1_voted, p1_pulse, p1_alarm;
  logic [7:0] p1_cnt;
  logic [1:0] p1_fid, p1_state;

  int n_vec;
  int n_err;

  tmr_fault_monitor #(.CNT_W(8), .PERSIST(3)) u_p3 (
    .clock(clk), .reset(rst), .a_in(ta), .b_in(tb), .c_in(tc), .clear(tclr),
    .voted(p3_voted), .err_pulse(p3_pulse), .err_count(p3_cnt),
    .fault_id(p3_fid), .alarm(p3_alarm), .state(p3_state));

  tmr_fault_monitor #(.CNT_W(8), .PERSIST(2)) u_p2 (
    .clock(clk), .reset(rst), .a_in(ta), .b_in(tb), .c_in(tc), .clear(tclr),
    .voted(p2_voted), .err_pulse(p2_pulse), .err_count(p2_cnt),
    .fault_id(p2_fid), .alarm(p2_alarm), .state(p2_state));

  tmr_fault_monitor #(.CNT_W(4), .PERSIST(3)) u_c4 (
    .clock(clk), .reset(rst), .a_in(ta), .b_in(tb), .c_in(tc), .clear(tclr),
    .voted(c4_voted), .err_pulse(c4_pulse), .err_count(c4_cnt),
    .fault_id(c4_fid), .alarm(c4_alarm), .state(c4_state));

  tmr_fault_monitor #(.CNT_W(8), .PERSIST(1)) u_p1 (
    .clock(clk), .reset(rst), .a_in(ta), .b_in(tb), .c_in(tc), .clear(tclr),
    .voted(p1_voted), .err_pulse(p1_pulse), .err_count(p1_cnt),
    .fault_id(p1_fid), .alarm(p1_alarm), .state(p1_state));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       a, b, c, clr;
    logic       v, p;
    logic [7:0] cnt;
    logic [1:0] fid;
    logic       al;
    logic [1:0] st;
  } vec_t;

  vec_t tbl [25];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic b, input logic c, input logic clr);
    ta = a; tb = b; tc = c; tclr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;

    // {a,b,c,clr, voted,pulse,cnt,fid,alarm,state} for the PERSIST=3 instance
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,8'd1,2'd0,1'b0,2'd1};
    tbl[1]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd1,2'd0,1'b0,2'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,8'd0,2'd0,1'b0,2'd0};
    tbl[3]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,8'd1,2'd0,1'b0,2'd1};
    tbl[4]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,8'd2,2'd0,1'b0,2'd1};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,8'd3,2'd3,1'b0,2'd2};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,8'd4,2'd3,1'b0,2'd2};
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,8'd5,2'd3,1'b0,2'd2};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,8'd6,2'd3,1'b0,2'd2};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,8'd7,2'd3,1'b0,2'd2};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,8'd8,2'd3,1'b0,2'd2};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,8'd0,2'd0,1'b0,2'd0};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,8'd1,2'd0,1'b0,2'd1};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,8'd2,2'd0,1'b0,2'd1};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,8'd3,2'd1,1'b0,2'd2};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,8'd4,2'd1,1'b0,2'd2};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,8'd5,2'd1,1'b0,2'd2};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd5,2'd1,1'b0,2'd2};
    tbl[18] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,8'd6,2'd1,1'b0,2'd2};
    tbl[19] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,8'd7,2'd1,1'b0,2'd2};
    tbl[20] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,8'd8,2'd1,1'b1,2'd3};
    tbl[21] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd8,2'd1,1'b1,2'd3};
    tbl[22] = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,8'd8,2'd1,1'b1,2'd3};
    tbl[23] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,8'd9,2'd1,1'b1,2'd3};
    tbl[24] = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,8'd0,2'd0,1'b0,2'd0};

    rst = 1'b1; ta = 1'b0; tb = 1'b0; tc = 1'b0; tclr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Build partial SUSPECT state, then reset asynchronously between edges
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_reset_state", {p3_voted, p3_cnt, p3_state}, {1'b1, 8'd2, 2'd1});
    #2 rst = 1'b1;
    #1;
    check("async_reset_p3", {p3_voted, p3_pulse, p3_cnt, p3_fid, p3_alarm, p3_state}, 32'd0);
    check("async_reset_c4", {c4_voted, c4_pulse, c4_cnt, c4_fid, c4_alarm, c4_state}, 32'd0);
    ta = 1'b1; tb = 1'b1; tc = 1'b1;
    #1 rst = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("post_reset", {p3_voted, p3_pulse, p3_cnt, p3_state}, {1'b1, 1'b0, 8'd0, 2'd0});

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr);
      check($sformatf("p3_vec%0d", i),
            {p3_voted, p3_pulse, p3_cnt, p3_fid, p3_alarm, p3_state},
            {tbl[i].v, tbl[i].p, tbl[i].cnt, tbl[i].fid, tbl[i].al, tbl[i].st});
    end

    // PERSIST=2: alternating offenders never accumulate a run
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("p2_alternate", {p2_cnt, p2_fid, p2_alarm, p2_state}, {8'd4, 2'd0, 1'b0, 2'd1});

    // PERSIST=1: faults immediately, second offender alarms immediately
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("p1_fault", {p1_fid, p1_alarm, p1_state}, {2'd2, 1'b0, 2'd2});
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("p1_double", {p1_fid, p1_alarm, p1_state}, {2'd2, 1'b1, 2'd3});

    // CNT_W=4: saturation and clear beating increment
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("c4_cnt14", c4_cnt, 4'd14);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("c4_cnt15", c4_cnt, 4'd15);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("c4_saturate", {c4_cnt, c4_fid, c4_state}, {4'd15, 2'd1, 2'd2});
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("c4_clear", {c4_pulse, c4_cnt, c4_fid, c4_alarm, c4_state}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("c4_after_clear", {c4_pulse, c4_cnt, c4_state}, {1'b1, 4'd1, 2'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
